// File: rtl/fixed_rrelu_pkg.sv
// fixed_rrelu_pkg: slope constants, lane seeds and saturation shared by the RReLU stream
package fixed_rrelu_pkg;
  localparam int MAXW = 128;
  typedef logic signed [MAXW-1:0] wide_t;
  function automatic logic [MAXW-1:0] slope_mask(input int f, input int upper, input int lower);
    return ((MAXW'(1) << (f - upper)) - MAXW'(1)) & ~((MAXW'(1) << (f - lower)) - MAXW'(1));
  endfunction
  function automatic logic [MAXW-1:0] mean_slope(input int f, input int upper, input int lower);
    return (MAXW'(1) << (f - upper - 1)) + (MAXW'(1) << (f - lower - 1));
  endfunction
  function automatic logic [MAXW-1:0] lane_seed(input logic [31:0] seed, input int i, input int w);
    logic [31:0] m;
    logic [MAXW-1:0] s, all;
    m = seed ^ (32'(i) * 32'h9E3779B9);
    all = (MAXW'(1) << w) - MAXW'(1);
    s = {{(MAXW-32){1'b0}}, m} & all;
    return s == '0 ? all : s;
  endfunction
  function automatic wide_t saturate(input wide_t v, input int w);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = ~hi;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/fixed_rrelu_lane.sv
// fixed_rrelu_lane: one RReLU lane (LFSR slope, multiply, shift/saturate), two register stages
// FIXED_RRELU_STREAM_ROUND_EN selects round-half-up on the negative path instead of floor.
module fixed_rrelu_lane import fixed_rrelu_pkg::*; #(
  parameter int IN_W = 32,
  parameter int F = 16,
  parameter int OUT_W = 32,
  parameter int OUT_F = 16,
  parameter int UPPER = 1,
  parameter int LOWER = 6,
  parameter logic [31:0] POLY = 32'h04c11db7,
  parameter logic [31:0] SEED = 32'hFFFFFFFF,
  parameter int LANE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             train,
  input  logic             en1,
  input  logic             en2,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);
  localparam int PW = IN_W + F + 1;
  localparam int S = 2 * F - OUT_F;
  localparam int P = F - OUT_F;
  localparam logic [IN_W-1:0] SEED_L = IN_W'(lane_seed(SEED, LANE, IN_W));
  localparam logic [F-1:0] MASK = F'(slope_mask(F, UPPER, LOWER));
  localparam logic [F-1:0] MEAN = F'(mean_slope(F, UPPER, LOWER));
  logic [IN_W-1:0] lfsr, lfsr_nxt;
  logic [F-1:0] slope;
  logic signed [PW-1:0] prod, s1_val;
  logic signed [PW:0] biased;
  logic s1_neg;
  wide_t shifted;
  assign lfsr_nxt = {lfsr[IN_W-2:0], 1'b0} ^ (lfsr[IN_W-1] ? IN_W'(POLY) : '0);
  // slope comes from the state this beat steps into
  assign slope = train ? lfsr_nxt[F-1:0] & MASK : MEAN;
  assign prod = PW'($signed(x)) * PW'($signed({1'b0, slope}));
  always_ff @(posedge clk)
    if (!rst_n) begin
      lfsr <= SEED_L;
      s1_val <= '0;
      s1_neg <= 1'b0;
    end else if (en1) begin
      lfsr <= lfsr_nxt;
      s1_val <= x[IN_W-1] ? prod : PW'($signed(x));
      s1_neg <= x[IN_W-1];
    end
`ifdef FIXED_RRELU_STREAM_ROUND_EN
  assign biased = (PW+1)'(s1_val) + ((PW+1)'(1) <<< (S - 1));
`else
  assign biased = (PW+1)'(s1_val);
`endif
  assign shifted = s1_neg ? wide_t'(biased >>> S) : wide_t'(s1_val >>> P);
  always_ff @(posedge clk)
    if (!rst_n) y <= '0;
    else if (en2) y <= OUT_W'(saturate(shifted, OUT_W));
endmodule

// File: rtl/fixed_rrelu_stream.sv
// fixed_rrelu_stream: N-lane pipelined randomised leaky ReLU with valid/ready back-pressure
// Build with FIXED_RRELU_STREAM_ROUND_EN for round-half-up on negative inputs.
module fixed_rrelu_stream import fixed_rrelu_pkg::*; #(
  parameter int DATA_IN_0_PRECISION_0 = 32,
  parameter int DATA_IN_0_PRECISION_1 = 16,
  parameter int DATA_OUT_0_PRECISION_0 = 32,
  parameter int DATA_OUT_0_PRECISION_1 = 16,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int UPPER = 1,
  parameter int LOWER = 6,
  parameter logic [31:0] LFSR_POLY = 32'h04c11db7,
  parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic train,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  output logic data_out_0_valid,
  input  logic data_out_0_ready
);
  localparam int N = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  logic s1_valid, adv1, adv2, accept;
  assign adv2 = ~data_out_0_valid | data_out_0_ready;
  assign adv1 = ~s1_valid | adv2;
  assign data_in_0_ready = rst_n & adv1;
  assign accept = data_in_0_valid & data_in_0_ready;
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      data_out_0_valid <= 1'b0;
    end else begin
      if (adv1) s1_valid <= data_in_0_valid;
      if (adv2) data_out_0_valid <= s1_valid;
    end
  for (genvar i = 0; i < N; i++) begin : g_lane
    fixed_rrelu_lane #(
      .IN_W(DATA_IN_0_PRECISION_0), .F(DATA_IN_0_PRECISION_1),
      .OUT_W(DATA_OUT_0_PRECISION_0), .OUT_F(DATA_OUT_0_PRECISION_1),
      .UPPER(UPPER), .LOWER(LOWER), .POLY(LFSR_POLY), .SEED(SEED), .LANE(i)
    ) u_lane (
      .clk(clk), .rst_n(rst_n), .train(train),
      .en1(accept), .en2(adv2 & s1_valid),
      .x(data_in_0[i]), .y(data_out_0[i])
    );
  end
endmodule

// File: tb/tb_fixed_rrelu_stream.sv
// tb_fixed_rrelu_stream: directed + random checks of fixed_rrelu_stream against an arithmetic model
module tb_fixed_rrelu_stream;
  localparam int F = 16, UPPER = 1, LOWER = 6;
  localparam logic [31:0] POLY = 32'h04c11db7, SEED = 32'hFFFFFFFF;
  localparam longint MEAN = (longint'(1) << (F - UPPER - 1)) + (longint'(1) << (F - LOWER - 1));
  typedef struct { logic [31:0] y; bit m1; bit tr; } exp_t;
  logic clk = 0, rst_n = 0, train = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] din [1], dout [1];
  logic v8 = 0, r8, ov8;
  logic [31:0] din8 [1];
  logic [15:0] dout8 [1];
  int checks = 0, errors = 0, n_acc = 0, ri = 0;
  bit recording = 0, replaying = 0;
  logic [31:0] lfsr_m = SEED, held;
  logic [31:0] xs [8];
  exp_t exp_q[$];
  logic [31:0] rec[$];
  always #5 clk = ~clk;
  fixed_rrelu_stream dut (
    .clk(clk), .rst_n(rst_n), .train(train), .data_in_0(din), .data_in_0_valid(in_valid),
    .data_in_0_ready(in_ready), .data_out_0(dout), .data_out_0_valid(out_valid), .data_out_0_ready(out_ready));
  fixed_rrelu_stream #(.DATA_OUT_0_PRECISION_0(16), .DATA_OUT_0_PRECISION_1(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .train(1'b0), .data_in_0(din8), .data_in_0_valid(v8),
    .data_in_0_ready(r8), .data_out_0(dout8), .data_out_0_valid(ov8), .data_out_0_ready(1'b1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[31] ? (s << 1) ^ POLY : s << 1;
  endfunction
  function automatic longint ref_out(input longint x, input longint slope);
    longint v, hi;
    if (x >= 0) v = x;
    else begin
      v = x * slope;
`ifdef FIXED_RRELU_STREAM_ROUND_EN
      v += longint'(1) << (F - 1);
`endif
      v = v >>> F;
    end
    hi = (longint'(1) << 31) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction
  task automatic step(input logic v, input logic [31:0] x, input logic tr, input logic ordy);
    exp_t e;
    longint slope, sl;
    in_valid = v; din[0] = x; train = tr; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("out", dout[0], e.y);
        if (e.m1 && e.tr) begin
          sl = -longint'($signed(dout[0]));
          chk("slope_grid", {31'b0, (sl % 1024 == 0) && sl >= 0 && sl <= 31744}, 32'd1);
        end
        if (recording) rec.push_back(dout[0]);
        if (replaying && ri < rec.size()) begin
          chk("replay", dout[0], rec[ri]);
          ri++;
        end
      end
    end
    if (in_valid && in_ready) begin
      lfsr_m = lfsr_step(lfsr_m);
      slope = tr ? ((longint'(lfsr_m) >> (F - LOWER)) % (longint'(1) << (LOWER - UPPER))) << (F - LOWER) : MEAN;
      e.y = 32'(ref_out(longint'($signed(x)), slope));
      e.m1 = (x == 32'hFFFF0000);
      e.tr = tr;
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drain();
    for (int k = 0; k < 10 && (exp_q.size() != 0 || out_valid); k++) step(0, 0, 0, 1);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask
  initial begin
    din[0] = 0; din8[0] = 0;
    for (int k = 0; k < 8; k++) xs[k] = (k % 2 == 0) ? 32'hFFFF0000 : (32'h80000000 | $urandom());
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", dout[0], 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1;
    // reference train-mode sequence straight after reset
    recording = 1;
    foreach (xs[k]) step(1, xs[k], 1, 1);
    drain();
    recording = 0;
    step(1, 32'hFFFF0000, 0, 1);
    step(0, 0, 0, 1);
    chk("eval_neg1_valid", {31'b0, out_valid}, 32'd1);
    chk("eval_neg1", dout[0], 32'hFFFFBE00);
    step(1, 32'h00038000, 0, 1);
    step(0, 0, 0, 1);
    chk("eval_pos", dout[0], 32'h00038000);
    step(1, 32'hFFFFFFFF, 0, 1);
    step(0, 0, 0, 1);
`ifdef FIXED_RRELU_STREAM_ROUND_EN
    chk("round_m1lsb", dout[0], 32'h00000000);
`else
    chk("round_m1lsb", dout[0], 32'hFFFFFFFF);
`endif
    drain();
    v8 = 1; din8[0] = 32'h00C80000;
    step(0, 0, 0, 1);
    v8 = 0;
    step(0, 0, 0, 1);
    chk("o8_valid", {31'b0, ov8}, 32'd1);
    chk("o8_sat", {16'b0, dout8[0]}, 32'h00007FFF);
    v8 = 1; din8[0] = 32'hFED40000;
    step(0, 0, 0, 1);
    v8 = 0;
    step(0, 0, 0, 1);
    chk("o8_neg300", {16'b0, dout8[0]}, 32'h0000B2A8);
    begin
      int base;
      base = n_acc;
      for (int k = 0; k < 5; k++) begin
        step(1, 32'h80000000 | $urandom(), 1, 0);
        if (k == 1) held = dout[0];
        if (k >= 2) chk("stall_hold", dout[0], held);
      end
      #1;
      chk("stall_acc", 32'(n_acc - base), 32'd2);
      chk("stall_ready", {31'b0, in_ready}, 32'd0);
    end
    drain();
    for (int k = 0; k < 1000; k++)
      step($urandom_range(3) != 0, ($urandom_range(3) == 0) ? 32'hFFFF0000 : (32'h80000000 | $urandom()), 1, $urandom_range(3) != 0);
    drain();
    step(1, 32'hFFFF0000, 1, 1);
    step(1, 32'hFFFF0000, 1, 0);
    rst_n = 0;
    step(0, 0, 1, 0);
    rst_n = 1;
    chk("rst_pulse_valid", {31'b0, out_valid}, 32'd0);
    lfsr_m = SEED;
    exp_q.delete();
    replaying = 1;
    foreach (xs[k]) step(1, xs[k], 1, 1);
    drain();
    replaying = 0;
    chk("replay_count", 32'(ri), 32'd8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
